// File: rtl/multicycle_control.sv
// Multicycle LEGv8 sequencing controller: decodes the IR opcode into a latched class and
// walks each instruction through FETCH/DECODE/EXEC/MEM/WB with memory handshakes.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [10:0]      Opcode,
  input  logic             Zero,
  input  logic             IReady,
  input  logic             DReady,
  output logic             IReq,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic [2:0]       SignOp,
  output logic             ALUSrc,
  output logic [3:0]       ALUOp,
  output logic             Reg2Loc,
  output logic             DReq,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             Illegal,
  output logic [CNT_W-1:0] Retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_B    = 4'd0,
    C_CBZ  = 4'd1,
    C_LDUR = 4'd2,
    C_STUR = 4'd3,
    C_ADD  = 4'd4,
    C_SUB  = 4'd5,
    C_AND  = 4'd6,
    C_ORR  = 4'd7,
    C_ADDI = 4'd8,
    C_SUBI = 4'd9,
    C_MOVZ = 4'd10,
    C_ILL  = 4'd11
  } cls_t;

  state_t           state_r;
  cls_t             class_r;
  logic             illegal_r;
  logic [CNT_W-1:0] retired_r;

  function automatic cls_t decode_class(input logic [10:0] op);
    cls_t c;
    casez (op)
      11'b000101?????: c = C_B;
      11'b10110100???: c = C_CBZ;
      11'b11111000010: c = C_LDUR;
      11'b11111000000: c = C_STUR;
      11'b10001011000: c = C_ADD;
      11'b11001011000: c = C_SUB;
      11'b10001010000: c = C_AND;
      11'b10101010000: c = C_ORR;
      11'b1001000100?: c = C_ADDI;
      11'b1101000100?: c = C_SUBI;
      11'b110100101??: c = C_MOVZ;
      default:         c = C_ILL;
    endcase
    return c;
  endfunction

  // R-type and the trap class have no immediate; they fall through to the B encoding.
  function automatic logic [2:0] sign_of(input cls_t c);
    logic [2:0] s;
    case (c)
      C_ADDI, C_SUBI: s = 3'b001;
      C_LDUR, C_STUR: s = 3'b010;
      C_CBZ:          s = 3'b011;
      C_MOVZ:         s = 3'b100;
      default:        s = 3'b000;
    endcase
    return s;
  endfunction

  // Sequencer state, latched class, sticky trap flag and retired-instruction counter.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_r   <= S_FETCH;
      class_r   <= C_B;
      illegal_r <= 1'b0;
      retired_r <= '0;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (IReady) begin
            state_r <= S_DECODE;
          end else begin
            state_r <= S_FETCH;
          end
        end
        S_DECODE: begin
          class_r <= decode_class(Opcode);
          if (decode_class(Opcode) == C_ILL) begin
            state_r   <= S_TRAP;
            illegal_r <= 1'b1;
          end else begin
            state_r <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (class_r)
            C_ADD, C_SUB, C_AND, C_ORR, C_ADDI, C_SUBI, C_MOVZ: state_r <= S_WB;
            C_LDUR, C_STUR: state_r <= S_MEM;
            C_B, C_CBZ: begin
              state_r   <= S_FETCH;
              retired_r <= retired_r + CNT_W'(1);
            end
            default: begin
              state_r   <= S_TRAP;
              illegal_r <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (!DReady) begin
            state_r <= S_MEM;
          end else if (class_r == C_LDUR) begin
            state_r <= S_WB;
          end else begin
            state_r   <= S_FETCH;
            retired_r <= retired_r + CNT_W'(1);
          end
        end
        S_WB: begin
          state_r   <= S_FETCH;
          retired_r <= retired_r + CNT_W'(1);
        end
        S_TRAP: begin
          state_r <= S_TRAP;
        end
        default: begin
          state_r <= S_FETCH;
        end
      endcase
    end
  end

  // Control decode from state and class; forced quiet while Reset is high.
  always_comb begin
    IReq     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    SignOp   = 3'b000;
    ALUSrc   = 1'b0;
    ALUOp    = 4'b0000;
    Reg2Loc  = 1'b0;
    DReq     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    if (!Reset) begin
      SignOp = sign_of(class_r);
      case (state_r)
        S_FETCH: begin
          IReq    = 1'b1;
          IRWrite = IReady;
          PCWrite = IReady;
        end
        S_EXEC: begin
          case (class_r)
            C_ADD: ALUOp = 4'b0010;
            C_SUB: ALUOp = 4'b0110;
            C_AND: ALUOp = 4'b0000;
            C_ORR: ALUOp = 4'b0001;
            C_ADDI: begin
              ALUSrc = 1'b1;
              ALUOp  = 4'b0010;
            end
            C_SUBI: begin
              ALUSrc = 1'b1;
              ALUOp  = 4'b0110;
            end
            C_MOVZ: begin
              ALUSrc = 1'b1;
              ALUOp  = 4'b0111;
            end
            C_LDUR, C_STUR: begin
              ALUSrc  = 1'b1;
              ALUOp   = 4'b0010;
              Reg2Loc = 1'b1;
            end
            C_B: begin
              PCWrite = 1'b1;
              PCSrc   = 1'b1;
            end
            C_CBZ: begin
              Reg2Loc = 1'b1;
              ALUOp   = 4'b0111;
              PCSrc   = 1'b1;
              PCWrite = Zero;
            end
            default: begin
              ALUOp = 4'b0000;
            end
          endcase
        end
        S_MEM: begin
          DReq     = 1'b1;
          MemRead  = (class_r == C_LDUR);
          MemWrite = (class_r == C_STUR);
        end
        S_WB: begin
          RegWrite = 1'b1;
          MemtoReg = (class_r == C_LDUR);
        end
        default: begin
          IReq = 1'b0;
        end
      endcase
    end else begin
      SignOp = 3'b000;
    end
  end

  assign Illegal = illegal_r;
  assign Retired = retired_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors and retired count.
module tb_multicycle_control;
  logic        CLK = 1'b0;
  logic        Reset, Zero, IReady, DReady;
  logic [10:0] Opcode;
  logic        IReq, IRWrite, PCWrite, PCSrc, ALUSrc, Reg2Loc;
  logic        DReq, MemRead, MemWrite, RegWrite, MemtoReg, Illegal;
  logic [2:0]  SignOp;
  logic [3:0]  ALUOp;
  logic [31:0] Retired;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_ret;
  logic [2:0]  prev_sign;
  logic [18:0] exp_v;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100011;
  localparam logic [10:0] OP_MOVZ = 11'b11010010101;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_BAD  = 11'b00000000000;

  // {IReq,IRWrite,PCWrite,PCSrc,ALUSrc,Reg2Loc,DReq,MemRead,MemWrite,RegWrite,MemtoReg,Illegal}
  localparam logic [11:0] V_NONE  = 12'b0000_0000_0000;
  localparam logic [11:0] V_FETCH = 12'b1110_0000_0000;
  localparam logic [11:0] V_FWAIT = 12'b1000_0000_0000;
  localparam logic [11:0] V_WB    = 12'b0000_0000_0100;
  localparam logic [11:0] V_WBL   = 12'b0000_0000_0110;
  localparam logic [11:0] V_EXLS  = 12'b0000_1100_0000;
  localparam logic [11:0] V_MEML  = 12'b0000_0011_0000;
  localparam logic [11:0] V_MEMS  = 12'b0000_0010_1000;
  localparam logic [11:0] V_EXB   = 12'b0011_0000_0000;
  localparam logic [11:0] V_CBZ1  = 12'b0011_0100_0000;
  localparam logic [11:0] V_CBZ0  = 12'b0001_0100_0000;
  localparam logic [11:0] V_EXMZ  = 12'b0000_1000_0000;
  localparam logic [11:0] V_TRAP  = 12'b0000_0000_0001;

  wire [18:0] obs = {IReq, IRWrite, PCWrite, PCSrc, ALUSrc, Reg2Loc, DReq, MemRead,
                     MemWrite, RegWrite, MemtoReg, Illegal, SignOp, ALUOp};

  multicycle_control #(.CNT_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .IReady(IReady), .DReady(DReady),
    .IReq(IReq), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .SignOp(SignOp),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .Reg2Loc(Reg2Loc), .DReq(DReq), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Illegal(Illegal),
    .Retired(Retired)
  );

  always #5 CLK = ~CLK;

  task automatic adv;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1; Zero = 1'b0; IReady = 1'b0; DReady = 1'b0; Opcode = OP_BAD;
    repeat (2) @(posedge CLK);
    #1;
    exp_v = {V_NONE, 3'b000, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_outputs got=%b want=%b", obs, exp_v); end
    checks++; if (Retired !== 32'd0) begin errors++; $display("FAIL reset_retired got=%0d want=0", Retired); end
    Reset = 1'b0;
    #1;
    exp_v = {V_FWAIT, 3'b000, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_release_ireq got=%b want=%b", obs, exp_v); end
    exp_ret = 32'd0;
    prev_sign = 3'b000;
  endtask

  task automatic test_rtype(input logic [10:0] op, input logic [3:0] aop, input string nm);
    Opcode = op; IReady = 1'b1; DReady = 1'b1;
    #1;
    exp_v = {V_FETCH, prev_sign, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL %s_fetch got=%b want=%b", nm, obs, exp_v); end
    adv;
    exp_v = {V_NONE, prev_sign, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL %s_decode got=%b want=%b", nm, obs, exp_v); end
    adv;
    exp_v = {V_NONE, 3'b000, aop};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL %s_exec got=%b want=%b", nm, obs, exp_v); end
    adv;
    exp_v = {V_WB, 3'b000, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL %s_wb got=%b want=%b", nm, obs, exp_v); end
    checks++; if (Retired !== exp_ret) begin errors++; $display("FAIL %s_wb_retired got=%0d want=%0d", nm, Retired, exp_ret); end
    adv;
    exp_ret = exp_ret + 32'd1;
    exp_v = {V_FETCH, 3'b000, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL %s_next_fetch got=%b want=%b", nm, obs, exp_v); end
    checks++; if (Retired !== exp_ret) begin errors++; $display("FAIL %s_retired got=%0d want=%0d", nm, Retired, exp_ret); end
    prev_sign = 3'b000;
  endtask

  task automatic test_ldur_wait;
    Opcode = OP_LDUR; IReady = 1'b1; DReady = 1'b0;
    #1;
    exp_v = {V_FETCH, prev_sign, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL ldur_fetch got=%b want=%b", obs, exp_v); end
    adv;
    adv;
    exp_v = {V_EXLS, 3'b010, 4'b0010};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL ldur_exec got=%b want=%b", obs, exp_v); end
    adv;
    for (int i = 0; i < 4; i++) begin
      DReady = (i == 3);
      #1;
      exp_v = {V_MEML, 3'b010, 4'b0000};
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL ldur_mem%0d got=%b want=%b", i, obs, exp_v); end
      adv;
    end
    exp_v = {V_WBL, 3'b010, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL ldur_wb got=%b want=%b", obs, exp_v); end
    adv;
    exp_ret = exp_ret + 32'd1;
    exp_v = {V_FETCH, 3'b010, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL ldur_next_fetch got=%b want=%b", obs, exp_v); end
    checks++; if (Retired !== exp_ret) begin errors++; $display("FAIL ldur_retired got=%0d want=%0d", Retired, exp_ret); end
    prev_sign = 3'b010;
  endtask

  task automatic test_cbz(input logic z);
    Opcode = OP_CBZ; IReady = 1'b1; DReady = 1'b1;
    #1;
    exp_v = {V_FETCH, prev_sign, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL cbz%0d_fetch got=%b want=%b", z, obs, exp_v); end
    adv;
    Zero = ~z;
    #1;
    exp_v = {V_NONE, prev_sign, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL cbz%0d_decode got=%b want=%b", z, obs, exp_v); end
    adv;
    Zero = z;
    #1;
    exp_v = {(z ? V_CBZ1 : V_CBZ0), 3'b011, 4'b0111};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL cbz%0d_exec got=%b want=%b", z, obs, exp_v); end
    adv;
    Zero = ~z;
    #1;
    exp_ret = exp_ret + 32'd1;
    exp_v = {V_FETCH, 3'b011, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL cbz%0d_next_fetch got=%b want=%b", z, obs, exp_v); end
    checks++; if (Retired !== exp_ret) begin errors++; $display("FAIL cbz%0d_retired got=%0d want=%0d", z, Retired, exp_ret); end
    prev_sign = 3'b011;
  endtask

  task automatic test_movz_b;
    Opcode = OP_MOVZ; IReady = 1'b0; DReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      exp_v = {V_FWAIT, prev_sign, 4'b0000};
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL movz_fetch_wait%0d got=%b want=%b", i, obs, exp_v); end
      adv;
    end
    IReady = 1'b1;
    #1;
    exp_v = {V_FETCH, prev_sign, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL movz_fetch got=%b want=%b", obs, exp_v); end
    adv;
    adv;
    exp_v = {V_EXMZ, 3'b100, 4'b0111};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL movz_exec got=%b want=%b", obs, exp_v); end
    adv;
    exp_v = {V_WB, 3'b100, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL movz_wb got=%b want=%b", obs, exp_v); end
    adv;
    Opcode = OP_B;
    #1;
    exp_ret = exp_ret + 32'd1;
    exp_v = {V_FETCH, 3'b100, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL b_fetch got=%b want=%b", obs, exp_v); end
    checks++; if (Retired !== exp_ret) begin errors++; $display("FAIL movz_retired got=%0d want=%0d", Retired, exp_ret); end
    adv;
    adv;
    Opcode = OP_BAD;
    #1;
    exp_v = {V_EXB, 3'b000, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL b_exec got=%b want=%b", obs, exp_v); end
    adv;
    exp_ret = exp_ret + 32'd1;
    exp_v = {V_FETCH, 3'b000, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL b_next_fetch got=%b want=%b", obs, exp_v); end
    checks++; if (Retired !== exp_ret) begin errors++; $display("FAIL b_retired got=%0d want=%0d", Retired, exp_ret); end
    prev_sign = 3'b000;
  endtask

  task automatic test_illegal;
    Opcode = OP_BAD; IReady = 1'b1; DReady = 1'b1;
    #1;
    adv;
    exp_v = {V_NONE, prev_sign, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL ill_decode got=%b want=%b", obs, exp_v); end
    adv;
    for (int i = 0; i < 20; i++) begin
      Zero = i[0];
      Opcode = OP_ADD;
      #1;
      exp_v = {V_TRAP, 3'b000, 4'b0000};
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL ill_trap%0d got=%b want=%b", i, obs, exp_v); end
      checks++; if (Retired !== exp_ret) begin errors++; $display("FAIL ill_retired%0d got=%0d want=%0d", i, Retired, exp_ret); end
      adv;
    end
    Reset = 1'b1;
    #1;
    exp_v = {V_NONE, 3'b000, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL ill_reset got=%b want=%b", obs, exp_v); end
    adv;
    Reset = 1'b0;
    #1;
    exp_ret = 32'd0;
    exp_v = {V_FETCH, 3'b000, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL ill_restart got=%b want=%b", obs, exp_v); end
    checks++; if (Retired !== exp_ret) begin errors++; $display("FAIL ill_reset_retired got=%0d want=0", Retired); end
    prev_sign = 3'b000;
  endtask

  task automatic test_reset_mid_mem;
    Opcode = OP_STUR; IReady = 1'b1; DReady = 1'b0;
    #1;
    adv;
    adv;
    exp_v = {V_EXLS, 3'b010, 4'b0010};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL stur_exec got=%b want=%b", obs, exp_v); end
    adv;
    for (int i = 0; i < 2; i++) begin
      #1;
      exp_v = {V_MEMS, 3'b010, 4'b0000};
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL stur_mem%0d got=%b want=%b", i, obs, exp_v); end
      if (i == 0) adv;
    end
    #1;
    Reset = 1'b1;
    #1;
    exp_v = {V_NONE, 3'b000, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL stur_async_reset got=%b want=%b", obs, exp_v); end
    checks++; if (Retired !== 32'd0) begin errors++; $display("FAIL stur_reset_retired got=%0d want=0", Retired); end
    DReady = 1'b1;
    adv;
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL stur_reset_held got=%b want=%b", obs, exp_v); end
    Reset = 1'b0;
    #1;
    exp_v = {V_FETCH, 3'b000, 4'b0000};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL stur_restart got=%b want=%b", obs, exp_v); end
    checks++; if (Retired !== 32'd0) begin errors++; $display("FAIL stur_restart_retired got=%0d want=0", Retired); end
    exp_ret = 32'd0;
    prev_sign = 3'b000;
  endtask

  initial begin
    test_reset;
    test_rtype(OP_ADD, 4'b0010, "add");
    test_rtype(OP_SUB, 4'b0110, "sub");
    test_ldur_wait;
    test_cbz(1'b1);
    test_cbz(1'b0);
    test_movz_b;
    test_illegal;
    test_rtype(OP_ADD, 4'b0010, "add_pre_stur");
    test_reset_mid_mem;
    test_rtype(OP_ADD, 4'b0010, "add_after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
